// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keyboard event controller:
// prefix byte values, decoder state encoding and the event record.
package kb_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam int         EV_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

endpackage

// File: rtl/kb_fifo.sv
// First-word-fall-through event FIFO, 2^W_SIZE entries of DW bits.
// Pointers carry one extra bit so that full and empty can be told apart.
module kb_fifo #(
  parameter int W_SIZE = 2,
  parameter int DW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << W_SIZE;
  localparam logic [W_SIZE:0] PTR_ONE = {{W_SIZE{1'b0}}, 1'b1};

  logic [W_SIZE:0] wr_ptr;
  logic [W_SIZE:0] rd_ptr;
  logic [DW-1:0]   mem [DEPTH];
  logic            do_pop;
  logic            do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[W_SIZE] != rd_ptr[W_SIZE]) &&
                 (wr_ptr[W_SIZE-1:0] == rd_ptr[W_SIZE-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = rd & ~empty;
  assign do_push = wr & (~full | do_pop);

  assign rdata = mem[rd_ptr[W_SIZE-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[W_SIZE-1:0]] <= wdata;
  end

endmodule

// File: rtl/kb_ctrl.sv
// PS/2 scan-code decoder feeding an event FIFO; optional typematic repeat
// filter enabled by defining KB_CTRL_TYPEMATIC_FILTER_EN.
//
// state      | meaning
// IDLE       | no prefix seen
// EXT        | E0 prefix seen
// BRK        | F0 prefix seen
// EXT_BRK    | E0 then F0 seen
module kb_ctrl
  import kb_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  output logic       rx_en,
  input  logic       rd,
  output logic [7:0] key_code,
  output logic       key_brk,
  output logic       key_ext,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  kb_state_t   state_q;
  kb_state_t   state_d;
  kb_event_t   ev;
  kb_event_t   head;
  logic        ev_valid;
  logic        push;
  logic [EV_W-1:0] fifo_rdata;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev.code  = scan_code;
    ev.ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    ev.brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    if (scan_done_tick) begin
      case (scan_code)
        BYTE_E0: state_d = ST_EXT;
        BYTE_F0: begin
          case (state_q)
            ST_IDLE: state_d = ST_BRK;
            ST_EXT:  state_d = ST_EXT_BRK;
            default: state_d = state_q;
          endcase
        end
        default: begin
          ev_valid = 1'b1;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

`ifdef KB_CTRL_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_valid;
  logic       make_match;
  logic       is_repeat;

  assign make_match = last_valid && (last_make == {ev.ext, ev.code});
  assign is_repeat  = ev_valid && !ev.brk && make_match;
  assign push       = ev_valid && !is_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_make  <= '0;
    end else if (ev_valid) begin
      if (!ev.brk && !make_match) begin
        last_make  <= {ev.ext, ev.code};
        last_valid <= 1'b1;
      end else if (ev.brk && make_match) begin
        last_valid <= 1'b0;
      end
    end
  end
`else
  assign push = ev_valid;
`endif

  kb_fifo #(
    .W_SIZE(W_SIZE),
    .DW    (EV_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr   (push),
    .rd   (rd),
    .wdata(ev),
    .rdata(fifo_rdata),
    .empty(empty),
    .full (full)
  );

  // A simultaneous pop makes room, so only an unpaired push into full drops.
  always_ff @(posedge clk) begin
    if (reset)                             overflow <= 1'b0;
    else if (push && full && !(rd && !empty)) overflow <= 1'b1;
  end

  assign rx_en    = ~full;
  assign head     = kb_event_t'(fifo_rdata);
  assign key_code = empty ? 8'h00 : head.code;
  assign key_brk  = empty ? 1'b0  : head.brk;
  assign key_ext  = empty ? 1'b0  : head.ext;

endmodule

// File: tb/tb_kb_ctrl.sv
// Directed and randomized checks of kb_ctrl against a queue-based model
// of the keyboard event stream (default W_SIZE=2, four-entry FIFO).
module tb_kb_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_done_tick = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       rd = 1'b0;
  logic       rx_en;
  logic [7:0] key_code;
  logic       key_brk;
  logic       key_ext;
  logic       empty;
  logic       full;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  // reference model: pending prefix flags, event queue, sticky overflow
  logic [9:0] q[$];
  bit         pend_ext, pend_brk, m_ovf;
  bit         lm_valid;
  logic [8:0] lm;

  kb_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .scan_done_tick(scan_done_tick),
    .scan_code     (scan_code),
    .rx_en         (rx_en),
    .rd            (rd),
    .key_code      (key_code),
    .key_brk       (key_brk),
    .key_ext       (key_ext),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input logic [7:0] c, input bit p);
    bit         pop_now, push_now, was_full;
    logic [9:0] ev;
    if (r) begin
      q.delete();
      pend_ext = 0; pend_brk = 0; m_ovf = 0; lm_valid = 0; lm = '0;
      return;
    end
    was_full = (q.size() == DEPTH);
    pop_now  = p && (q.size() > 0);
    push_now = 0;
    ev       = '0;
    if (t) begin
      if (c == 8'hE0) begin
        pend_ext = 1; pend_brk = 0;
      end else if (c == 8'hF0) begin
        pend_brk = 1;
      end else begin
        ev = {pend_ext, pend_brk, c};
        pend_ext = 0; pend_brk = 0;
        push_now = 1;
`ifdef KB_CTRL_TYPEMATIC_FILTER_EN
        if (!ev[8]) begin
          if (lm_valid && lm == {ev[9], ev[7:0]}) push_now = 0;
          else begin lm = {ev[9], ev[7:0]}; lm_valid = 1; end
        end else if (lm_valid && lm == {ev[9], ev[7:0]}) begin
          lm_valid = 0;
        end
`endif
      end
    end
    if (pop_now) void'(q.pop_front());
    if (push_now) begin
      if (was_full && !pop_now) m_ovf = 1;
      else q.push_back(ev);
    end
  endtask

  task automatic check_outputs();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h000;
    chk("empty",    {9'b0, empty},    {9'b0, q.size() == 0});
    chk("full",     {9'b0, full},     {9'b0, q.size() == DEPTH});
    chk("rx_en",    {9'b0, rx_en},    {9'b0, q.size() != DEPTH});
    chk("overflow", {9'b0, overflow}, {9'b0, m_ovf});
    chk("key_code", {2'b0, key_code}, {2'b0, h[7:0]});
    chk("key_brk",  {9'b0, key_brk},  {9'b0, h[8]});
    chk("key_ext",  {9'b0, key_ext},  {9'b0, h[9]});
  endtask

  task automatic cyc(input bit r, input bit t, input logic [7:0] c, input bit p);
    reset = r; scan_done_tick = t; scan_code = c; rd = p;
    @(posedge clk);
    model_step(r, t, c, p);
    #1;
    reset = 1'b0; scan_done_tick = 1'b0; rd = 1'b0;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] c);
    cyc(0, 1, c, 0);
  endtask

  task automatic pop();
    cyc(0, 0, 8'h00, 1);
  endtask

  initial begin
    int         sel;
    logic [7:0] b;
    bit         r, t, p;

    cyc(1, 1, 8'h55, 1);                        // reset wins over tick and rd
    cyc(0, 0, 8'h00, 0);
    send(8'h1C);                                // single make, visible next cycle
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);      // extended release
    send(8'h1C);                                // decoder back in idle
    pop(); pop(); pop();
    cyc(1, 0, 8'h00, 0);
    send(8'h15); send(8'h16); send(8'h17); send(8'h18);  // fill
    send(8'h19);                                // dropped, overflow
    pop(); pop(); pop(); pop(); pop();          // last pop is on empty
    cyc(1, 0, 8'h00, 0);
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    cyc(0, 1, 8'h2A, 1);                        // push+pop while full
    pop(); pop(); pop(); pop();
    send(8'hE0);
    cyc(1, 0, 8'h00, 0);                        // discard pending prefix
    send(8'h6B);
    pop();
    cyc(1, 0, 8'h00, 0);
    send(8'h1C); send(8'h1C); pop(); send(8'h1C);
    send(8'hF0); send(8'h1C); pop(); send(8'h1C); pop(); pop(); pop();

    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      t   = ($urandom_range(0, 2) != 0);
      p   = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5, 6:    b = 8'h1C;
        7:       b = 8'h2A;
        default: b = 8'($urandom_range(0, 255));
      endcase
      cyc(r, t, b, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
